// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone DMA engine and its bus neighbours.
package wb_dma_pkg;
  localparam int WB_ADDR_WIDTH = 20;
  localparam int DATA_WIDTH    = 8;
  localparam int DMA_LEN_WIDTH = 16;
  // Controller port index of the DMA engine on wb_demux (SPI bridge 0, video fetch 1)
  localparam int WB_DMA        = 2;

  typedef enum logic {COPY = 1'b0, FILL = 1'b1} dma_mode_t;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
  } dma_state_t;
endpackage

// File: rtl/wb_dma.sv
// Wishbone bus-master DMA: copies a byte range upward or fills it with a constant,
// releasing the bus cycle between every access.
module wb_dma
  import wb_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic [ADDR_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] fill_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i
);

  dma_state_t            state, state_next;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [LEN_WIDTH-1:0]  remaining;
  dma_mode_t             mode;
  logic [DATA_WIDTH-1:0] fill, data;
  logic                  abort_seen;
  logic                  aborted;

  logic accept, byte_done, last_byte, rd_phase, wr_phase;

  assign accept    = (state == IDLE) && start_i;
  assign byte_done = (state == WR_WAIT) && wb_ack_i;
  assign last_byte = (remaining == LEN_WIDTH'(1));
  assign rd_phase  = (state == RD_REQ) || (state == RD_WAIT);
  assign wr_phase  = (state == WR_REQ) || (state == WR_WAIT);

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0)                    state_next = FINISH;
          else if (dma_mode_t'(mode_i) == FILL) state_next = WR_REQ;
          else                                state_next = RD_REQ;
        end
      end
      RD_REQ:  if (!wb_stall_i) state_next = RD_WAIT;
      RD_WAIT: if (wb_ack_i)    state_next = WR_REQ;
      WR_REQ:  if (!wb_stall_i) state_next = WR_WAIT;
      WR_WAIT: begin
        if (wb_ack_i) begin
          if (last_byte || abort_i) state_next = FINISH;
          else if (mode == FILL)    state_next = WR_REQ;
          else                      state_next = RD_REQ;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      src        <= '0;
      dst        <= '0;
      remaining  <= '0;
      mode       <= COPY;
      fill       <= '0;
      data       <= '0;
      abort_seen <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (accept) begin
        aborted    <= 1'b0;
        abort_seen <= 1'b0;
        if (len_i != '0) begin
          src       <= src_i;
          dst       <= dst_i;
          remaining <= len_i;
          mode      <= dma_mode_t'(mode_i);
          fill      <= fill_i;
        end
      end
      if ((state == RD_WAIT) && wb_ack_i) data <= wb_data_i;
      // Abort only counts when it cut the run short of its final byte
      if (byte_done) begin
        src        <= src + ADDR_WIDTH'(1);
        dst        <= dst + ADDR_WIDTH'(1);
        remaining  <= remaining - LEN_WIDTH'(1);
        abort_seen <= abort_i && !last_byte;
      end
      if ((state == FINISH) && abort_seen) aborted <= 1'b1;
    end
  end

  // Cycle falls in the acknowledging cycle so the demux can re-arbitrate at once
  always_comb begin
    busy_o      = rd_phase || wr_phase;
    done_o      = (state == FINISH);
    aborted_o   = aborted;
    wb_strobe_o = (state == RD_REQ) || (state == WR_REQ);
    wb_cycle_o  = wb_strobe_o ||
                  (((state == RD_WAIT) || (state == WR_WAIT)) && !wb_ack_i);
    wb_we_o     = wr_phase;
    wb_addr_o   = '0;
    wb_data_o   = '0;
    if (wr_phase) begin
      wb_addr_o = dst;
      wb_data_o = (mode == FILL) ? fill : data;
    end else if (rd_phase) begin
      wb_addr_o = src;
    end
  end

endmodule

// File: tb/tb_wb_dma.sv
// Bench for wb_dma: Wishbone RAM slave with random stall/ack latency, checked
// against a byte-level transfer model.
module tb_wb_dma;
  import wb_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, mode, abort, stall, ack;
  logic [19:0] src, dst;
  logic [15:0] len;
  logic [7:0]  fill, rdata;
  logic        busy, done, aborted, we, cycle, strobe;
  logic [19:0] addr;
  logic [7:0]  wdata;

  always #5 clk = ~clk;

  wb_dma dut (
    .wb_clock_i(clk), .wb_reset_i(rst), .start_i(start), .mode_i(mode),
    .src_i(src), .dst_i(dst), .len_i(len), .fill_i(fill), .abort_i(abort),
    .busy_o(busy), .done_o(done), .aborted_o(aborted),
    .wb_addr_o(addr), .wb_data_o(wdata), .wb_data_i(rdata), .wb_we_o(we),
    .wb_cycle_o(cycle), .wb_strobe_o(strobe), .wb_stall_i(stall), .wb_ack_i(ack)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [logic [19:0]];
  logic [7:0]  mdl [logic [19:0]];
  logic [28:0] log_q [$];
  logic [28:0] exp_q [$];

  bit stall_en = 0;
  int max_dly  = 0;
  bit no_ack   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [19:0] a);
    return mdl.exists(a) ? mdl[a] : (a[7:0] ^ 8'hA5);
  endfunction

  // Wishbone RAM slave: drives stall/ack just after the falling edge, then
  // inspects the settled request for the coming rising edge.
  bit          pend, held, pend_we;
  int          wcnt;
  logic [19:0] pend_addr, h_addr;
  logic [7:0]  h_data;
  logic        h_we;

  always begin
    @(negedge clk);
    if (rst) begin
      pend = 0; held = 0; ack = 0; stall = 0; rdata = 8'h00;
    end else begin
      ack = 0;
      if (pend) begin
        if (wcnt == 0) begin
          ack = 1;
          rdata = pend_we ? 8'h00 : mem_rd(pend_addr);
          pend = 0;
        end else wcnt--;
      end
      stall = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
      #1;
      if (held) begin
        chk("stall_strobe", strobe, 1'b1);
        chk("stall_addr", addr, h_addr);
        chk("stall_data", wdata, h_data);
        chk("stall_we", we, h_we);
      end
      held = 0;
      if (ack) chk("cycle_drop", cycle, 1'b0);
      if (strobe) begin
        if (stall) begin
          held = 1; h_addr = addr; h_data = wdata; h_we = we;
        end else begin
          pend = 1; pend_we = we; pend_addr = addr;
          wcnt = no_ack ? 1000000 : $urandom_range(0, max_dly);
          if (we) mem[addr] = wdata;
          log_q.push_back({we, addr, we ? wdata : 8'h00});
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Command inputs are scrambled after the start pulse to prove they were latched
  task automatic start_cmd(input bit m, input logic [19:0] s, input logic [19:0] d,
                           input logic [15:0] n, input logic [7:0] f);
    start = 1; mode = m; src = s; dst = d; len = n; fill = f;
    tick();
    start = 0;
    mode = 1'($urandom); src = 20'($urandom); dst = 20'($urandom);
    len = 16'($urandom); fill = 8'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 2000) begin
      tick();
      cycles++;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_with_done", busy, 1'b0);
    tick();
    chk("done_pulse_end", done, 1'b0);
  endtask

  task automatic model_run(input bit m, input logic [19:0] s, input logic [19:0] d,
                           input int n, input logic [7:0] f);
    logic [19:0] sa, da;
    logic [7:0]  b;
    for (int i = 0; i < n; i++) begin
      sa = s + 20'(i);
      da = d + 20'(i);
      if (m == 1'b0) begin
        b = mdl_rd(sa);
        exp_q.push_back({1'b0, sa, 8'h00});
      end else b = f;
      mdl[da] = b;
      exp_q.push_back({1'b1, da, b});
    end
  endtask

  task automatic check_run(input string tag, input logic [19:0] d, input int n);
    logic [19:0] a;
    chk({tag, "_accesses"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk({tag, "_access"}, log_q[i], exp_q[i]);
    for (int i = 0; i <= n; i++) begin
      a = d + 20'(i);
      chk({tag, "_mem"}, mem_rd(a), mdl_rd(a));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    bit          m;
    logic [19:0] s, d;
    logic [15:0] n;
    logic [7:0]  f, b;

    rst = 1; start = 0; mode = 0; src = '0; dst = '0; len = '0; fill = '0; abort = 0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cycle", cycle, 1'b0);
    chk("rst_strobe", strobe, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_addr", addr, 20'h0);
    rst = 0;
    tick();

    // Fill 4 bytes, zero-wait bus: 2 cycles per byte
    start_cmd(1'b1, 20'h00000, 20'h08000, 16'd4, 8'h20);
    chk("fill_busy_n1", busy, 1'b1);
    chk("fill_strobe_n1", strobe, 1'b1);
    model_run(1'b1, 20'h00000, 20'h08000, 4, 8'h20);
    wait_done(cyc);
    chk("fill_latency", cyc, 8);
    check_run("fill", 20'h08000, 4);

    // Scroll copy 3 bytes: 4 cycles per byte, read before write
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      mem[20'h08028 + 20'(i)] = b;
      mdl[20'h08028 + 20'(i)] = b;
    end
    start_cmd(1'b0, 20'h08028, 20'h08000, 16'd3, 8'h00);
    chk("copy_busy_n1", busy, 1'b1);
    model_run(1'b0, 20'h08028, 20'h08000, 3, 8'h00);
    wait_done(cyc);
    chk("copy_latency", cyc, 12);
    check_run("copy", 20'h08000, 3);

    // Random commands under random stall and ack latency
    stall_en = 1; max_dly = 3;
    for (int r = 0; r < 8; r++) begin
      m = 1'($urandom);
      s = (r % 3 == 0) ? 20'hFFFFA : 20'($urandom_range(0, 20'h0FFFF));
      d = (r % 2 == 0) ? s + 20'($urandom_range(0, 3)) : 20'($urandom);
      n = 16'($urandom_range(1, 10));
      f = 8'($urandom);
      start_cmd(m, s, d, n, f);
      model_run(m, s, d, int'(n), f);
      wait_done(cyc);
      chk("rand_aborted", aborted, 1'b0);
      check_run("rand", d, int'(n));
    end
    stall_en = 0; max_dly = 0;

    // Abort while the third byte waits for its write ack
    start_cmd(1'b1, 20'h0, 20'h09000, 16'd10, 8'h3C);
    for (int k = 0; k < 100 && log_q.size() < 3; k++) tick();
    tick();
    abort = 1;
    model_run(1'b1, 20'h0, 20'h09000, 3, 8'h3C);
    wait_done(cyc);
    abort = 0;
    chk("abort_flag", aborted, 1'b1);
    check_run("abort", 20'h09000, 10);

    // Zero length: no bus traffic, done right after the start edge, clears abort flag
    start_cmd(1'b1, 20'h0, 20'h0A000, 16'd0, 8'hFF);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_aborted_clr", aborted, 1'b0);
    tick();
    chk("len0_done_end", done, 1'b0);
    chk("len0_no_access", log_q.size(), 0);

    // Destination wraps past the top of the address space
    start_cmd(1'b1, 20'h0, 20'hFFFFF, 16'd2, 8'h77);
    model_run(1'b1, 20'h0, 20'hFFFFF, 2, 8'h77);
    wait_done(cyc);
    check_run("wrap", 20'hFFFFF, 2);

    // Reset while a read is outstanding
    no_ack = 1;
    start_cmd(1'b0, 20'h08100, 20'h08200, 16'd5, 8'h00);
    tick();
    chk("rdwait_cycle", cycle, 1'b1);
    chk("rdwait_strobe", strobe, 1'b0);
    rst = 1;
    #1;
    chk("rstmid_cycle", cycle, 1'b0);
    chk("rstmid_strobe", strobe, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    tick();
    rst = 0;
    no_ack = 0;
    log_q.delete();
    tick();
    start_cmd(1'b1, 20'h0, 20'h0B000, 16'd2, 8'h5E);
    chk("post_rst_busy", busy, 1'b1);
    model_run(1'b1, 20'h0, 20'h0B000, 2, 8'h5E);
    wait_done(cyc);
    chk("post_rst_latency", cyc, 4);
    check_run("post_rst", 20'h0B000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
